// File: rtl/gcd_pkg.sv
// Shared width default and FSM state encoding for the GCD engine.
package gcd_pkg;

    localparam int GCD_W = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } gcd_state_t;

endpackage

// File: rtl/gcd_step.sv
// One Euclid subtraction step: subtract when a>=b, otherwise swap the operands.
module gcd_step
    import gcd_pkg::*;
#(
    parameter int W = GCD_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] a_nxt,
    output logic [W-1:0] b_nxt,
    output logic         b_zero
);

    always_comb begin
        b_zero = (b == '0);
        a_nxt  = a;
        b_nxt  = b;
        // a>=b guards the subtract, so the difference never wraps
        if (a >= b) begin
            a_nxt = a - b;
        end else begin
            a_nxt = b;
            b_nxt = a;
        end
    end

endmodule

// File: rtl/gcd_engine.sv
// Iterative subtraction-based GCD with a valid/ready request port and a held result.
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int W = GCD_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         out_valid,
    output logic [W-1:0] GCD
);

    gcd_state_t   state_q, state_d;
    logic [W-1:0] a_q, b_q, gcd_q;
    logic [W-1:0] a_nxt, b_nxt;
    logic         b_zero;
    logic         accept;

    gcd_step #(.W(W)) u_step (
        .a      (a_q),
        .b      (b_q),
        .a_nxt  (a_nxt),
        .b_nxt  (b_nxt),
        .b_zero (b_zero)
    );

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (in_valid) state_d = CALC;
            CALC:       if (b_zero)   state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    // Operands and result; the result register only moves when a run finishes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            gcd_q <= '0;
        end else if (accept) begin
            a_q <= A;
            b_q <= B;
        end else if (state_q == CALC) begin
            if (b_zero) begin
                gcd_q <= a_q;
            end else begin
                a_q <= a_nxt;
                b_q <= b_nxt;
            end
        end
    end

    always_comb begin
        in_ready  = (state_q != CALC);
        out_valid = (state_q == DONE);
        GCD       = gcd_q;
    end

endmodule

// File: tb/tb_gcd_engine.sv
// Directed and random checks of gcd_engine against hand values and a modulo-based model.
module tb_gcd_engine;

    localparam int W = 7;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         out_valid;
    logic [W-1:0] GCD;

    int n_cmp = 0;
    int n_err = 0;

    int dva[15] = '{90, 48, 65, 48, 8, 125, 85, 54, 95, 109, 75, 0, 0, 9, 64};
    int dvb[15] = '{86, 12,  4,  7, 2,   6, 76, 44, 32,  91, 34, 0, 9, 0, 64};
    int dvg[15] = '{ 2, 12,  1,  1, 2,   1,  1,  2,  1,   1,  1, 0, 9, 9, 64};

    gcd_engine #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .GCD       (GCD)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_gcd(input int x, input int y);
        int p, q, t;
        p = x;
        q = y;
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    // Called at a negedge; returns 1 ns after the accepting edge
    task automatic send(input int a, input int b);
        int budget;
        logic ok;
        budget = 300;
        while (!in_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        ok = in_ready;
        chk("ready_to", ok, 1);
        in_valid = 1'b1;
        A = a[W-1:0];
        B = b[W-1:0];
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("ov_clr", out_valid, 0);
        chk("rdy_calc", in_ready, 0);
    endtask

    task automatic wait_done(output logic [W-1:0] g, output int cyc);
        logic done;
        done = 1'b0;
        cyc = 0;
        while (!done && cyc < 300) begin
            @(negedge clk);
            if (out_valid) done = 1'b1;
            else cyc++;
        end
        chk("done_to", done, 1);
        g = GCD;
    endtask

    initial begin
        logic [W-1:0] g;
        int cyc, ra, rb;

        #12;
        chk("rst_ov", out_valid, 0);
        chk("rst_rdy", in_ready, 1);
        chk("rst_gcd", GCD, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Leave a nonzero result behind so the abort visibly clears it
        send(90, 86);
        wait_done(g, cyc);
        chk("pre_abort", g, 2);
        send(127, 1);
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ov", out_valid, 0);
        chk("abort_gcd", GCD, 0);
        chk("abort_rdy", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(48, 12);
        wait_done(g, cyc);
        chk("post_abort", g, 12);

        for (int i = 0; i < 15; i++) begin
            send(dva[i], dvb[i]);
            wait_done(g, cyc);
            chk($sformatf("dir_%0d_%0d", dva[i], dvb[i]), g, dvg[i]);
            repeat (i % 3) @(negedge clk);
        end

        // Worst case: 127 subtracts, one swap, one finishing step
        send(127, 1);
        cyc = 0;
        begin
            logic done;
            done = 1'b0;
            while (!done && cyc < 300) begin
                @(negedge clk);
                if (out_valid) begin
                    in_valid = 1'b0;
                    done = 1'b1;
                end else begin
                    cyc++;
                    chk("calc_rdy", in_ready, 0);
                    in_valid = $urandom_range(0, 1);
                    A = W'($urandom);
                    B = W'($urandom);
                end
            end
            chk("lat_done", done, 1);
        end
        chk("lat_cyc", cyc, 129);
        chk("lat_gcd", GCD, 1);
        @(negedge clk);
        chk("lat_hold", GCD, 1);
        chk("lat_ov", out_valid, 1);

        // Back-to-back: second accept in the first DONE cycle
        send(48, 12);
        wait_done(g, cyc);
        chk("b2b_first", g, 12);
        send(65, 4);
        chk("b2b_hold", GCD, 12);
        wait_done(g, cyc);
        chk("b2b_second", g, 1);

        for (int i = 0; i < 1000; i++) begin
            ra = int'($urandom_range(0, (1 << W) - 1));
            rb = int'($urandom_range(0, (1 << W) - 1));
            send(ra, rb);
            wait_done(g, cyc);
            chk($sformatf("rnd_%0d_%0d", ra, rb), g, ref_gcd(ra, rb));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
